// File: rtl/max_reduce_seq.sv
// max_reduce_seq: burst-reduction sequencer for an external combinational
// approximate 2-operand max unit. Each operand in a burst is paired with the
// running max (acc). One result is returned per burst over valid/ready.
// Optional build macro: MAX_ERR_MON_EN adds an err_cnt output. That counter
// records every accumulate step where the max unit disagrees with an exact max.
module max_reduce_seq #(
  parameter int unsigned W      = 5,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned ERRC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [W-1:0]      m_data,
  output logic [W-1:0]      mx_a,
  output logic [W-1:0]      mx_b,
  input  logic [W-1:0]      mx_y,
  output logic              busy
`ifdef MAX_ERR_MON_EN
  ,
  output logic [ERRC_W-1:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     acc;
  logic [LEN_W-1:0] rem;

  logic             s_hs;
  logic             m_hs;
  logic [LEN_W-1:0] first_rem;

  // Max unit operands: running max and the operand currently offered.
  assign mx_a = acc;
  assign mx_b = s_data;

  // Handshakes and the remaining-count loaded on a burst's first operand.
  always_comb begin
    s_hs      = s_valid & s_ready;
    m_hs      = m_valid & m_ready;
    first_rem = (cfg_len == '0) ? '0 : LEN_W'(cfg_len - LEN_W'(1));
  end

  // Sequencer FSM; flush outranks both handshakes in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      rem     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      s_ready <= 1'b1;
      busy    <= 1'b0;
    end else if (flush) begin
      state   <= ST_IDLE;
      acc     <= '0;
      rem     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      s_ready <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_hs) begin
            acc  <= s_data;
            rem  <= first_rem;
            busy <= 1'b1;
            if (first_rem == '0) begin
              state   <= ST_OUT;
              m_valid <= 1'b1;
              m_data  <= s_data;
              s_ready <= 1'b0;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          if (s_hs) begin
            acc <= mx_y;
            rem <= LEN_W'(rem - LEN_W'(1));
            if (rem == LEN_W'(1)) begin
              state   <= ST_OUT;
              m_valid <= 1'b1;
              m_data  <= mx_y;
              s_ready <= 1'b0;
            end
          end
        end
        ST_OUT: begin
          if (m_hs) begin
            state   <= ST_IDLE;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MAX_ERR_MON_EN
  logic [W-1:0] exact_max;
  logic         mon_step;

  // Exact reference max and the qualifying accumulate step.
  always_comb begin
    exact_max = (acc >= s_data) ? acc : s_data;
    mon_step  = (state == ST_ACC) && s_hs && !flush;
  end

  // Saturating mismatch counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (mon_step && (mx_y != exact_max) && (err_cnt != {ERRC_W{1'b1}})) begin
      err_cnt <= ERRC_W'(err_cnt + ERRC_W'(1));
    end
  end
`endif

endmodule

// File: tb/tb_max_reduce_seq.sv
// Bench for max_reduce_seq: a behavioural max unit (exact, forced-zero, or
// return-A) and a queue of expected burst results.
module tb_max_reduce_seq;

  localparam int unsigned W      = 5;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned ERRC_W = 8;

  logic              clk;
  logic              rst_n;
  logic [LEN_W-1:0]  cfg_len;
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [W-1:0]      s_data;
  logic              m_valid;
  logic              m_ready;
  logic [W-1:0]      m_data;
  logic [W-1:0]      mx_a;
  logic [W-1:0]      mx_b;
  logic [W-1:0]      mx_y;
  logic              busy;
`ifdef MAX_ERR_MON_EN
  logic [ERRC_W-1:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0 exact max, 1 forced zero, 2 returns operand A
  logic [W-1:0] sb[$];

  max_reduce_seq #(.W(W), .LEN_W(LEN_W), .ERRC_W(ERRC_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .mx_a(mx_a), .mx_b(mx_b), .mx_y(mx_y), .busy(busy)
`ifdef MAX_ERR_MON_EN
    , .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural max unit.
  always_comb begin
    case (mode)
      1:       mx_y = '0;
      2:       mx_y = mx_a;
      default: mx_y = (mx_a >= mx_b) ? mx_a : mx_b;
    endcase
  end

  function automatic logic [W-1:0] ref_max(input logic [W-1:0] d[$]);
    logic [W-1:0] m;
    m = d[0];
    foreach (d[i]) if (d[i] > m) m = d[i];
    return m;
  endfunction

  // Drive one burst back-to-back; ends right after the last accepting edge.
  task automatic send_ops(input logic [LEN_W-1:0] len, input logic [W-1:0] d[$]);
    foreach (d[i]) begin
      int n;
      n = 0;
      @(negedge clk);
      cfg_len = len;
      s_valid = 1'b1;
      s_data  = d[i];
      while (!s_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!s_ready) begin
        checks++; errors++;
        $display("FAIL send_ops s_ready timeout data=%0d", d[i]);
      end
      @(posedge clk);
    end
  endtask

  task automatic run_burst(input logic [LEN_W-1:0] len, input logic [W-1:0] d[$],
                           input logic [W-1:0] exp);
    sb.push_back(exp);
    send_ops(len, d);
  endtask

  // Wait (bounded) for a result, compare with scoreboard, complete handshake.
  task automatic get_result(input string nm);
    int n;
    logic [W-1:0] exp;
    n = 0;
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (!m_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!m_valid) begin
      errors++;
      $display("FAIL %s m_valid timeout", nm);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected result m_data=%0d", nm, m_data);
    end else begin
      exp = sb.pop_front();
      if (m_data !== exp) begin
        errors++;
        $display("FAIL %s m_data got=%0d exp=%0d", nm, m_data, exp);
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle busy=%b m_valid=%b s_ready=%b exp 0/0/1", nm, busy, m_valid, s_ready);
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] d[$];
    rst_n = 1'b0;
    #12;
    check_idle("reset_state");
    checks++;
    if (m_data !== '0 || mx_a !== '0) begin
      errors++;
      $display("FAIL reset_data m_data=%0d acc=%0d exp 0/0", m_data, mx_a);
    end
`ifdef MAX_ERR_MON_EN
    checks++;
    if (err_cnt !== '0) begin
      errors++;
      $display("FAIL reset_errcnt got=%0d exp=0", err_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    // Partial burst, then asynchronous reset in the middle of ACC.
    d = '{5'd2, 5'd9};
    send_ops(4'd4, d);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midacc_busy got=%b exp=1", busy);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    d = '{5'd7};
    run_burst(4'd1, d, 5'd7);
    get_result("reset_len1");
  endtask

  task automatic test_burst();
    logic [W-1:0] d[$];
    d = '{5'd3, 5'd17, 5'd9, 5'd12};
    run_burst(4'd4, d, ref_max(d));
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 5'd17) begin
      errors++;
      $display("FAIL burst_latency m_valid=%b m_data=%0d exp 1/17", m_valid, m_data);
    end
    get_result("burst4");
    @(negedge clk);
    check_idle("burst_after_hs");
  endtask

  task automatic test_len_edge();
    logic [W-1:0] d[$];
    mode = 1;
    d = '{5'd21};
    run_burst(4'd0, d, 5'd21);
    get_result("len0");
    run_burst(4'd1, d, 5'd21);
    get_result("len1");
    mode = 0;
    d = {};
    for (int i = 0; i < 15; i++) d.push_back(W'(i));
    run_burst(4'd15, d, ref_max(d));
    get_result("len15_ramp");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d[$];
    logic [W-1:0] hold;
    d = '{5'd30, 5'd4, 5'd11};
    run_burst(4'd3, d, ref_max(d));
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 5'd31;
    hold    = m_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== hold || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure cyc=%0d m_valid=%b m_data=%0d s_ready=%b exp 1/%0d/0",
                 i, m_valid, m_data, s_ready, hold);
      end
    end
    get_result("backpressure");
    @(negedge clk);
    check_idle("backpressure_release");
  endtask

  task automatic test_flush();
    logic [W-1:0] d[$];
    d = '{5'd20, 5'd25};
    send_ops(4'd4, d);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 5'd31;
    flush   = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
    s_valid = 1'b0;
    check_idle("flush_idle");
    checks++;
    if (mx_a !== '0) begin
      errors++;
      $display("FAIL flush_acc got=%0d exp=0", mx_a);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_result cyc=%0d m_valid=%b exp=0", i, m_valid);
      end
    end
    d = '{5'd5, 5'd6};
    run_burst(4'd2, d, ref_max(d));
    get_result("flush_then_len2");
  endtask

`ifdef MAX_ERR_MON_EN
  task automatic test_err_mon();
    logic [W-1:0] d[$];
    mode = 2;
    d = '{5'd4, 5'd10};
    run_burst(4'd2, d, 5'd4);
    get_result("errmon_approx");
    checks++;
    if (err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL errmon_one got=%0d exp=1", err_cnt);
    end
    // 22 bursts x 14 mismatching accumulate steps, well past saturation.
    d = {5'd0};
    for (int i = 0; i < 14; i++) d.push_back(5'd31);
    for (int b = 0; b < 22; b++) begin
      run_burst(4'd15, d, 5'd0);
      get_result("errmon_sat_burst");
    end
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL errmon_saturate got=%0d exp=255", err_cnt);
    end
    mode = 0;
  endtask
`endif

  initial begin
    rst_n   = 1'b1;
    cfg_len = '0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    test_reset();
    test_burst();
    test_len_edge();
    test_back_to_back();
    test_flush();
`ifdef MAX_ERR_MON_EN
    test_err_mon();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover size=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
